// File: rtl/vx_lsu_agen_pkg.sv
// rtl/vx_lsu_agen_pkg.sv - shared types and constants for the LSU address-generation stage
package vx_lsu_agen_pkg;

    localparam int LSU_NUM_THREADS = 4;
    localparam int LSU_NW_BITS     = 2;
    localparam int LSU_NR_BITS     = 5;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        RUN        = 1'b0,
        FENCE_WAIT = 1'b1
    } agen_state_t;

    typedef struct packed {
        logic [LSU_NW_BITS-1:0]        wid;
        logic [LSU_NUM_THREADS-1:0]    tmask;
        logic [31:0]                   pc;
        logic [3:0]                    op_type;
        logic                          is_fence;
        logic                          is_prefetch;
        logic [LSU_NUM_THREADS*32-1:0] store_data;
        logic [LSU_NUM_THREADS*32-1:0] addr;
        logic [LSU_NR_BITS-1:0]        rd;
        logic                          wb;
`ifdef LSU_AGEN_MISALIGN_EN
        logic [LSU_NUM_THREADS-1:0]    misaligned;
`endif
    } lsu_entry_t;

    function automatic logic lane_misaligned(input logic [1:0] size, input logic [31:0] addr);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr[0];
            SIZE_WORD: return addr[1:0] != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vx_lsu_agen_if.sv
// rtl/vx_lsu_agen_if.sv - request/issue bundle between dispatch, address generation and memory request stage
interface vx_lsu_agen_if #(
    parameter int NUM_THREADS = 4,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 5
);
    logic                      req_valid;
    logic [NW_BITS-1:0]        req_wid;
    logic [NUM_THREADS-1:0]    req_tmask;
    logic [31:0]               req_PC;
    logic [3:0]                req_op_type;
    logic                      req_is_fence;
    logic                      req_is_prefetch;
    logic [NUM_THREADS*32-1:0] req_store_data;
    logic [NUM_THREADS*32-1:0] req_base_addr;
    logic [31:0]               req_offset;
    logic [NR_BITS-1:0]        req_rd;
    logic                      req_wb;
    logic                      req_ready;

    logic                      agen_valid;
    logic [NW_BITS-1:0]        agen_wid;
    logic [NUM_THREADS-1:0]    agen_tmask;
    logic [31:0]               agen_PC;
    logic [3:0]                agen_op_type;
    logic [NR_BITS-1:0]        agen_rd;
    logic                      agen_wb;
    logic                      agen_is_prefetch;
    logic [NUM_THREADS*32-1:0] agen_store_data;
    logic [NUM_THREADS*32-1:0] agen_addr;
    logic [NUM_THREADS-1:0]    agen_misaligned;
    logic                      agen_ready;

    modport master (
        output req_valid, req_wid, req_tmask, req_PC, req_op_type, req_is_fence,
               req_is_prefetch, req_store_data, req_base_addr, req_offset, req_rd, req_wb,
        input  req_ready,
        input  agen_valid, agen_wid, agen_tmask, agen_PC, agen_op_type, agen_rd, agen_wb,
               agen_is_prefetch, agen_store_data, agen_addr, agen_misaligned,
        output agen_ready
    );

    modport slave (
        input  req_valid, req_wid, req_tmask, req_PC, req_op_type, req_is_fence,
               req_is_prefetch, req_store_data, req_base_addr, req_offset, req_rd, req_wb,
        output req_ready,
        output agen_valid, agen_wid, agen_tmask, agen_PC, agen_op_type, agen_rd, agen_wb,
               agen_is_prefetch, agen_store_data, agen_addr, agen_misaligned,
        input  agen_ready
    );
endinterface

// File: rtl/vx_lsu_agen_fifo.sv
// rtl/vx_lsu_agen_fifo.sv - generic DEPTH-entry synchronous FIFO with full/empty flags
module vx_lsu_agen_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr, rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is cleared on reset so the head reads as all-zero until the first push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
        end
    end

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

endmodule

// File: rtl/vx_lsu_agen.sv
// rtl/vx_lsu_agen.sv - LSU address generation, issue buffering and fence ordering
// Optional per-lane misalignment flags are built when LSU_AGEN_MISALIGN_EN is defined.
module vx_lsu_agen
    import vx_lsu_agen_pkg::*;
#(
    parameter int NUM_THREADS = LSU_NUM_THREADS,
    parameter int NW_BITS     = LSU_NW_BITS,
    parameter int NR_BITS     = LSU_NR_BITS,
    parameter int DEPTH       = 2,
    parameter int MAX_PENDING = 16
) (
    input  logic        clk,
    input  logic        reset,
    vx_lsu_agen_if.slave bus,
    input  logic        rsp_done,
    output logic        fence_busy
);
    localparam int              PW       = $clog2(MAX_PENDING + 1);
    localparam logic [PW-1:0]   PEND_MAX = PW'(MAX_PENDING);

    lsu_entry_t  enq, head;
    logic        full, empty, push, pop, issue, inc, dec;
    logic [PW-1:0] pending;
    agen_state_t state, state_n;

    always_comb begin
        enq             = '0;
        enq.wid         = bus.req_wid[NW_BITS-1:0];
        enq.tmask       = bus.req_tmask;
        enq.pc          = bus.req_PC;
        enq.op_type     = bus.req_op_type;
        enq.is_fence    = bus.req_is_fence;
        enq.is_prefetch = bus.req_is_prefetch;
        enq.store_data  = bus.req_store_data;
        enq.rd          = bus.req_rd[NR_BITS-1:0];
        enq.wb          = bus.req_wb;
        for (int i = 0; i < NUM_THREADS; i++) begin
            enq.addr[i*32 +: 32] = bus.req_base_addr[i*32 +: 32] + bus.req_offset;
`ifdef LSU_AGEN_MISALIGN_EN
            enq.misaligned[i] = bus.req_tmask[i]
                && lane_misaligned(bus.req_op_type[1:0], enq.addr[i*32 +: 32]);
`endif
        end
    end

    assign push          = bus.req_valid && !full;
    assign bus.req_ready = !full;

    vx_lsu_agen_fifo #(
        .WIDTH($bits(lsu_entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .wdata(enq),
        .rdata(head),
        .full (full),
        .empty(empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_n;
    end

    // A fence never reaches the memory stage; it is retired in place once pending drains.
    always_comb begin
        state_n    = state;
        pop        = 1'b0;
        issue      = 1'b0;
        fence_busy = 1'b0;
        case (state)
            RUN: begin
                if (!empty) begin
                    if (head.is_fence) begin
                        if (pending == '0) pop     = 1'b1;
                        else               state_n = FENCE_WAIT;
                    end else begin
                        issue = (pending < PEND_MAX) || head.is_prefetch;
                        pop   = issue && bus.agen_ready;
                    end
                end
            end
            FENCE_WAIT: begin
                fence_busy = 1'b1;
                if (pending == '0) begin
                    pop     = 1'b1;
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
    end

    assign inc = issue && bus.agen_ready && !head.is_prefetch;
    assign dec = rsp_done && (pending != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            pending <= '0;
        else if (inc && !dec) pending <= pending + 1'b1;
        else if (dec && !inc) pending <= pending - 1'b1;
    end

    assign bus.agen_valid       = issue;
    assign bus.agen_wid         = head.wid;
    assign bus.agen_tmask       = head.tmask;
    assign bus.agen_PC          = head.pc;
    assign bus.agen_op_type     = head.op_type;
    assign bus.agen_rd          = head.rd;
    assign bus.agen_wb          = head.wb;
    assign bus.agen_is_prefetch = head.is_prefetch;
    assign bus.agen_store_data  = head.store_data;
    assign bus.agen_addr        = head.addr;
`ifdef LSU_AGEN_MISALIGN_EN
    assign bus.agen_misaligned  = head.misaligned;
`else
    assign bus.agen_misaligned  = '0;
`endif

endmodule
